// File: rtl/compressor_3_to_1_pipe_pkg.sv
// Shared constants, carry bundle and stage-geometry helpers for the
// pipelined 3-operand compressor.
package compressor_pkg;

  localparam int SLICE_W = 8;

  // The two carries a slice hands to its upper neighbour.
  typedef struct packed {
    logic c3to2;
    logic cadd;
  } slice_carry_t;

  function automatic int num_stages(input int num_slices, input int stage_slices);
    return (num_slices + stage_slices - 1) / stage_slices;
  endfunction

  function automatic int stage_of(input int slice, input int stage_slices);
    return slice / stage_slices;
  endfunction

endpackage

// File: rtl/compressor_3_to_1_pipe_if.sv
// Operand/result bundle for compressor_3_to_1_pipe.
interface compressor_3_to_1_pipe_if #(
  parameter int WIDTH = 32
);
  // Handshake: no backpressure. On every rising edge with en=1 the operands
  // are consumed and in_valid marks them as a real request; out_valid marks
  // o/co as a real result. With en=0 both sides hold and inputs are ignored.
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             c3to2_in;
  logic             ci;
  logic             out_valid;
  logic [WIDTH-1:0] o;
  logic [1:0]       co;

  modport master (
    output en, in_valid, a, b, c, c3to2_in, ci,
    input  out_valid, o, co
  );

  modport slave (
    input  en, in_valid, a, b, c, c3to2_in, ci,
    output out_valid, o, co
  );
endinterface

// File: rtl/compressor_3_to_1_pipe_slice.sv
// One 8-bit 3:1 compressor slice: 3:2 carry-save stage followed by a
// carry-propagate add. Purely combinational.
module compressor_3_to_1_slice
  import compressor_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [SLICE_W-1:0] c,
  input  logic               c3to2_in,
  input  logic               ci,
  output logic [SLICE_W-1:0] o,
  output logic               c3to2_out,
  output logic               co
);

  logic [SLICE_W-1:0] s;
  logic [SLICE_W-1:0] t;

  assign s = a ^ b ^ c;
  assign t = (a & b) | (a & c) | (b & c);

  // t is weighted x2: its top bit leaves the slice, the rest shift up.
  assign {co, o} = {1'b0, s}
                 + {1'b0, t[SLICE_W-2:0], c3to2_in}
                 + {{SLICE_W{1'b0}}, ci};
  assign c3to2_out = t[SLICE_W-1];

endmodule

// File: rtl/compressor_3_to_1_pipe.sv
// Pipelined WIDTH-bit a+b+c+c3to2_in+ci built from chained 8-bit slices, with
// carry registers between stages and operand skew / sum deskew registers.
module compressor_3_to_1_pipe
  import compressor_pkg::*;
#(
  parameter int NUM_SLICES   = 4,
  parameter int STAGE_SLICES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  compressor_3_to_1_pipe_if.slave  bus
);

  localparam int WIDTH      = NUM_SLICES * SLICE_W;
  localparam int NUM_STAGES = num_stages(NUM_SLICES, STAGE_SLICES);

  logic [WIDTH-1:0]      o_w;
  logic [1:0]            co_q;
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    localparam int STG = stage_of(k, STAGE_SLICES);
    localparam int DSK = NUM_STAGES - STG;

    logic [SLICE_W-1:0] a_s, b_s, c_s;
    logic [SLICE_W-1:0] sum;
    slice_carry_t       cin;
    slice_carry_t       cout;
    logic [SLICE_W-1:0] dsk_q [DSK];

    if (STG == 0) begin : g_noskew
      assign a_s = bus.a[k*SLICE_W +: SLICE_W];
      assign b_s = bus.b[k*SLICE_W +: SLICE_W];
      assign c_s = bus.c[k*SLICE_W +: SLICE_W];
    end else begin : g_skew
      logic [3*SLICE_W-1:0] skew_q [STG];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STG; i++) skew_q[i] <= '0;
        end else if (bus.en) begin
          skew_q[0] <= {bus.a[k*SLICE_W +: SLICE_W], bus.b[k*SLICE_W +: SLICE_W],
                        bus.c[k*SLICE_W +: SLICE_W]};
          for (int i = 1; i < STG; i++) skew_q[i] <= skew_q[i-1];
        end
      end
      assign {a_s, b_s, c_s} = skew_q[STG-1];
    end

    // First slice of every later stage takes its carries from a register.
    if (k == 0) begin : g_cin_port
      assign cin = {bus.c3to2_in, bus.ci};
    end else if ((k % STAGE_SLICES) == 0) begin : g_cin_reg
      slice_carry_t carry_q;
      always_ff @(posedge clk) begin
        if (reset)       carry_q <= '0;
        else if (bus.en) carry_q <= g_slice[k-1].cout;
      end
      assign cin = carry_q;
    end else begin : g_cin_comb
      assign cin = g_slice[k-1].cout;
    end

    compressor_3_to_1_slice u_slice (
      .a         (a_s),
      .b         (b_s),
      .c         (c_s),
      .c3to2_in  (cin.c3to2),
      .ci        (cin.cadd),
      .o         (sum),
      .c3to2_out (cout.c3to2),
      .co        (cout.cadd)
    );

    // Last deskew entry doubles as this slice's share of the output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DSK; i++) dsk_q[i] <= '0;
      end else if (bus.en) begin
        dsk_q[0] <= sum;
        for (int i = 1; i < DSK; i++) dsk_q[i] <= dsk_q[i-1];
      end
    end
    assign o_w[k*SLICE_W +: SLICE_W] = dsk_q[DSK-1];
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      co_q  <= '0;
    end else if (bus.en) begin
      vld_q <= vld_d;
      co_q  <= {1'b0, g_slice[NUM_SLICES-1].cout.c3to2}
             + {1'b0, g_slice[NUM_SLICES-1].cout.cadd};
    end
  end

  assign bus.o         = o_w;
  assign bus.co        = co_q;
  assign bus.out_valid = vld_q[NUM_STAGES-1];

endmodule

// File: tb/tb_compressor_3_to_1_pipe.sv
// Bench for compressor_3_to_1_pipe: directed vector table, a modelled stream
// with stall and reset, and a small parameter sweep.
module tb_compressor_3_to_1_pipe;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  int       checks = 0;
  int       errors = 0;
  bit       sweep_go = 1'b0;
  bit [3:0] sweep_done = '0;

  always #5 clk = ~clk;

  compressor_3_to_1_pipe_if #(.WIDTH(W)) mif ();
  compressor_3_to_1_pipe #(.NUM_SLICES(4), .STAGE_SLICES(1)) dut (
    .clk(clk), .reset(rst), .bus(mif)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic         c3, ci;
    logic [W-1:0] exp_o;
    logic [1:0]   exp_co;
  } vec_t;

  vec_t         vecs [10];
  logic [W+1:0] exp_q [$];
  logic [W+1:0] mdl_d [LAT];
  logic         mdl_v [LAT];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W+1:0] ref_sum(input logic [W-1:0] a, b, c, input logic c3, ci);
    return {2'b0, a} + {2'b0, b} + {2'b0, c} + {{(W+1){1'b0}}, c3} + {{(W+1){1'b0}}, ci};
  endfunction

  task automatic drive(input logic en, v, input logic [W-1:0] a, b, c, input logic c3, ci);
    mif.en = en; mif.in_valid = v; mif.a = a; mif.b = b; mif.c = c;
    mif.c3to2_in = c3; mif.ci = ci;
  endtask

  task automatic stream_cycle(input logic en, v, r, input logic [W-1:0] a, b, c,
                              input logic c3, ci);
    drive(en, v, a, b, c, c3, ci);
    rst = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LAT; i++) begin mdl_v[i] = 1'b0; mdl_d[i] = '0; end
      exp_q.delete();
    end else if (en) begin
      for (int i = LAT-1; i > 0; i--) begin mdl_v[i] = mdl_v[i-1]; mdl_d[i] = mdl_d[i-1]; end
      mdl_v[0] = v;
      mdl_d[0] = ref_sum(a, b, c, c3, ci);
      if (v) exp_q.push_back(ref_sum(a, b, c, c3, ci));
    end
    #1;
    check("stream_valid", 64'(mif.out_valid), 64'(mdl_v[LAT-1]));
    check("stream_data", 64'({mif.co, mif.o}), 64'(mdl_d[LAT-1]));
    if (en && !r && mif.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: got %0h expected none", {mif.co, mif.o});
      end else begin
        check("sb_order", 64'({mif.co, mif.o}), 64'(exp_q.pop_front()));
      end
    end
  endtask

  // Sweep: each configuration gets its own DUT and runs all-ones plus randoms.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NS   = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 128;
    localparam int SS   = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 2;
    localparam int SW   = NS * 8;
    localparam int SLAT = (NS + SS - 1) / SS;

    compressor_3_to_1_pipe_if #(.WIDTH(SW)) sif ();
    compressor_3_to_1_pipe #(.NUM_SLICES(NS), .STAGE_SLICES(SS)) sdut (
      .clk(clk), .reset(rst), .bus(sif)
    );

    initial begin
      logic [SW-1:0] ra, rb, rc;
      logic          rc3, rci;
      logic [SW+1:0] e, got;
      int            lat;
      sif.en = 1'b1; sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.c = '0;
      sif.c3to2_in = 1'b0; sif.ci = 1'b0;
      wait (sweep_go);
      for (int t = 0; t < 3; t++) begin
        if (t == 0) begin
          ra = '1; rb = '1; rc = '1; rc3 = 1'b1; rci = 1'b1;
        end else begin
          ra = '0; rb = '0; rc = '0;
          for (int i = 0; i < NS; i++) begin
            ra = (ra << 8) | SW'($urandom_range(0, 255));
            rb = (rb << 8) | SW'($urandom_range(0, 255));
            rc = (rc << 8) | SW'($urandom_range(0, 255));
          end
          rc3 = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
        end
        e = {2'b0, ra} + {2'b0, rb} + {2'b0, rc} + {{(SW+1){1'b0}}, rc3} + {{(SW+1){1'b0}}, rci};
        @(posedge clk); #1;
        sif.a = ra; sif.b = rb; sif.c = rc; sif.c3to2_in = rc3; sif.ci = rci; sif.in_valid = 1'b1;
        @(posedge clk); #1;
        sif.in_valid = 1'b0; lat = 1;
        while (!sif.out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != SLAT) begin
          errors++;
          $display("FAIL sweep%0d_lat t=%0d: got %0d expected %0d", g, t, lat, SLAT);
        end
        got = {sif.co, sif.o};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL sweep%0d_sum t=%0d: got co=%0d lo=%h expected co=%0d lo=%h",
                   g, t, got[SW+1:SW], 64'(got), e[SW+1:SW], 64'(e));
        end
      end
      sweep_done[g] = 1'b1;
    end
  end

  initial begin
    int lat;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'd2};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 2'd1};
    vecs[2] = '{32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 1'b0, 1'b0, 32'h8181_8180, 2'd1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0002, 2'd0};
    vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'hBC00_4478, 2'd0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFE, 2'd1};
    vecs[7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 2'd1};
    vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFD, 2'd1};
    vecs[9] = '{32'h00FF_00FF, 32'hFF00_FF00, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 2'd1};

    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(mif.out_valid), 64'd0);
    check("reset_o", 64'(mif.o), 64'd0);
    check("reset_co", 64'(mif.co), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].c3, vecs[i].ci);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      lat = 1;
      while (!mif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_o", i), 64'(mif.o), 64'(vecs[i].exp_o));
      check($sformatf("vec%0d_co", i), 64'(mif.co), 64'(vecs[i].exp_co));
      @(posedge clk); #1;
    end

    // Stream with 1101 valid pattern, a 3-cycle stall and a reset taken with en=0.
    for (int n = 0; n < 110; n++) begin
      logic en_n, v_n, r_n;
      r_n  = (n == 0) || (n == 70);
      en_n = !((n >= 40 && n < 43) || n == 70);
      v_n  = (n > 0) && (n < 100) && ((n % 4) != 2);
      stream_cycle(en_n, v_n, r_n, $urandom(), $urandom(), $urandom(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    sweep_go = 1'b1;
    for (int i = 0; i < 3000 && sweep_done != 4'hF; i++) @(posedge clk);
    check("sweep_done", 64'(sweep_done), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
